// File: rtl/ecg_cnn_pkg.sv
// Shared state codes and default widths for the ECG CNN layers.
package ecg_cnn_pkg;

  localparam int DEF_N         = 16;
  localparam int DEF_SUM_WIDTH = 2 * DEF_N + 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MAC  = 3'd1,
    ST_ACT  = 3'd2,
    ST_EMIT = 3'd3,
    ST_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/ecg_mac_unit.sv
// Signed multiply-accumulate with sign-extended products.
// Define ECG_CONV_SAT_EN to clamp each accumulate instead of wrapping.
module ecg_mac_unit
  import ecg_cnn_pkg::*;
#(
  parameter int N         = DEF_N,
  parameter int SUM_WIDTH = DEF_SUM_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear,
  input  logic                        en,
  input  logic signed [N-1:0]         x,
  input  logic signed [N-1:0]         w,
  output logic signed [SUM_WIDTH-1:0] acc
);

  logic signed [2*N-1:0]       prod;
  logic signed [SUM_WIDTH-1:0] prod_ext;
  logic signed [SUM_WIDTH-1:0] acc_next;

  assign prod     = x * w;
  assign prod_ext = SUM_WIDTH'(prod);

`ifdef ECG_CONV_SAT_EN
  localparam logic [SUM_WIDTH-1:0] MAX_V = {1'b0, {(SUM_WIDTH-1){1'b1}}};
  localparam logic [SUM_WIDTH-1:0] MIN_V = {1'b1, {(SUM_WIDTH-1){1'b0}}};

  logic [SUM_WIDTH:0] wide;

  // One extra bit exposes overflow: top two bits differ only when the sum left the range.
  assign wide = {acc[SUM_WIDTH-1], acc} + {prod_ext[SUM_WIDTH-1], prod_ext};

  always_comb begin
    acc_next = wide[SUM_WIDTH-1:0];
    if (wide[SUM_WIDTH] != wide[SUM_WIDTH-1]) begin
      acc_next = wide[SUM_WIDTH] ? MIN_V : MAX_V;
    end
  end
`else
  assign acc_next = acc + prod_ext;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc_next;
    end
  end

endmodule

// File: rtl/ecg_conv_layer.sv
// Convolution layer: K-tap MAC windows, ReLU, P-way max-pool, NPOOL outputs per start.
// Saturating accumulation is selected with ECG_CONV_SAT_EN.
module ecg_conv_layer
  import ecg_cnn_pkg::*;
#(
  parameter int N         = DEF_N,
  parameter int K         = 3,
  parameter int P         = 2,
  parameter int NPOOL     = 4,
  parameter int SUM_WIDTH = 2 * N + 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [N-1:0]         xin,
  input  logic signed [N-1:0]         win,
  output logic                        out_valid,
  output logic signed [SUM_WIDTH-1:0] out_data,
  output logic                        busy,
  output logic                        done,
  output logic [2:0]                  state
);

  localparam logic [4:0] TAP_LAST  = 5'(K - 1);
  localparam logic [3:0] POOL_LAST = 4'(P - 1);
  localparam logic [8:0] OUT_LAST  = 9'(NPOOL - 1);

  state_t                      cur_state;
  state_t                      next_state;
  logic [4:0]                  tap_cnt;
  logic [3:0]                  pool_cnt;
  logic [8:0]                  out_cnt;
  logic signed [SUM_WIDTH-1:0] acc;
  logic signed [SUM_WIDTH-1:0] relu;
  logic signed [SUM_WIDTH-1:0] pool_max;
  logic signed [SUM_WIDTH-1:0] new_max;
  logic signed [SUM_WIDTH-1:0] out_reg;
  logic                        accept;
  logic                        mac_clear;

  assign accept    = (cur_state == ST_MAC) && in_valid;
  assign mac_clear = ((cur_state == ST_IDLE) && start) || (cur_state == ST_ACT);

  ecg_mac_unit #(
    .N         (N),
    .SUM_WIDTH (SUM_WIDTH)
  ) u_mac (
    .clk   (clk),
    .rst   (rst),
    .clear (mac_clear),
    .en    (accept),
    .x     (xin),
    .w     (win),
    .acc   (acc)
  );

  // First window of a pool overwrites the running max instead of comparing.
  assign relu    = acc[SUM_WIDTH-1] ? '0 : acc;
  assign new_max = ((pool_cnt == '0) || (relu > pool_max)) ? relu : pool_max;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_state <= ST_IDLE;
    end else begin
      cur_state <= next_state;
    end
  end

  always_comb begin
    next_state = cur_state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    done       = 1'b0;
    busy       = 1'b1;
    case (cur_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) next_state = ST_MAC;
      end
      ST_MAC: begin
        in_ready = 1'b1;
        if (accept && (tap_cnt == TAP_LAST)) next_state = ST_ACT;
      end
      ST_ACT: begin
        next_state = (pool_cnt == POOL_LAST) ? ST_EMIT : ST_MAC;
      end
      ST_EMIT: begin
        out_valid  = 1'b1;
        next_state = (out_cnt == OUT_LAST) ? ST_DONE : ST_MAC;
      end
      ST_DONE: begin
        done       = 1'b1;
        next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tap_cnt  <= '0;
      pool_cnt <= '0;
      out_cnt  <= '0;
      pool_max <= '0;
      out_reg  <= '0;
    end else begin
      case (cur_state)
        ST_IDLE: begin
          if (start) begin
            tap_cnt  <= '0;
            pool_cnt <= '0;
            out_cnt  <= '0;
          end
        end
        ST_MAC: begin
          if (accept) tap_cnt <= tap_cnt + 5'd1;
        end
        ST_ACT: begin
          pool_max <= new_max;
          tap_cnt  <= '0;
          if (pool_cnt == POOL_LAST) begin
            pool_cnt <= '0;
            out_reg  <= new_max;
          end else begin
            pool_cnt <= pool_cnt + 4'd1;
          end
        end
        ST_EMIT: begin
          if (out_cnt != OUT_LAST) out_cnt <= out_cnt + 9'd1;
        end
        default: ;
      endcase
    end
  end

  assign out_data = out_reg;
  assign state    = cur_state;

endmodule

// File: tb/tb_ecg_conv_layer.sv
// Directed bench: instance 0 (K=3,P=2,NPOOL=1,SUM_WIDTH=32), instance 1 (K=3,P=2,NPOOL=3).
module tb_ecg_conv_layer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] start_s = '0;
  logic [1:0] in_valid_s = '0;
  logic signed [15:0] xin = '0;
  logic signed [15:0] win = '0;

  logic [1:0] o_ready, o_valid, o_busy, o_done;
  logic [2:0] o_state0, o_state1;
  logic signed [31:0] data0;
  logic signed [35:0] data1;

  int total = 0;
  int bad = 0;

  int qx[$];
  int qw[$];
  longint out_vals[8];
  int out_cyc[8];
  int n_out;
  int done_cnt;
  int done_cyc;
  bit overlap;

  always #5 clk = ~clk;

  ecg_conv_layer #(.N(16), .K(3), .P(2), .NPOOL(1), .SUM_WIDTH(32)) dut0 (
    .clk(clk), .rst(rst), .start(start_s[0]), .in_valid(in_valid_s[0]),
    .in_ready(o_ready[0]), .xin(xin), .win(win), .out_valid(o_valid[0]),
    .out_data(data0), .busy(o_busy[0]), .done(o_done[0]), .state(o_state0)
  );

  ecg_conv_layer #(.N(16), .K(3), .P(2), .NPOOL(3)) dut1 (
    .clk(clk), .rst(rst), .start(start_s[1]), .in_valid(in_valid_s[1]),
    .in_ready(o_ready[1]), .xin(xin), .win(win), .out_valid(o_valid[1]),
    .out_data(data1), .busy(o_busy[1]), .done(o_done[1]), .state(o_state1)
  );

  function automatic longint get_data(input int sel);
    return (sel == 0) ? longint'(data0) : longint'(data1);
  endfunction

  function automatic int get_state(input int sel);
    return (sel == 0) ? int'(o_state0) : int'(o_state1);
  endfunction

  task automatic push_n(input int x, input int w, input int n);
    for (int i = 0; i < n; i++) begin
      qx.push_back(x);
      qw.push_back(w);
    end
  endtask

  // Cycle 1 is the start edge; outputs are sampled on the falling edge after each rising edge.
  task automatic run_layer(input int sel, input int stall_after, input int stall_len, input bit poke);
    int cyc;
    int accepted;
    int stall_left;
    bit ready_now;
    n_out = 0; done_cnt = 0; done_cyc = -1; overlap = 0;
    accepted = 0; stall_left = stall_len;
    @(negedge clk);
    start_s[sel] = 1'b1;
    in_valid_s[sel] = 1'b0;
    @(posedge clk);
    cyc = 1;
    while (cyc < 400) begin
      @(negedge clk);
      start_s[sel] = 1'b0;
      if (o_valid[sel] && o_done[sel]) overlap = 1;
      if (o_valid[sel]) begin
        if (n_out < 8) begin
          out_vals[n_out] = get_data(sel);
          out_cyc[n_out] = cyc;
        end
        n_out++;
        if (poke) start_s[sel] = 1'b1;
      end
      if (o_done[sel]) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
        if (poke) start_s[sel] = 1'b1;
      end
      if (poke && cyc == 3) start_s[sel] = 1'b1;
      if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
      if (accepted == stall_after && stall_left > 0) begin
        in_valid_s[sel] = 1'b0;
        stall_left--;
      end else if (qx.size() > 0) begin
        in_valid_s[sel] = 1'b1;
        xin = 16'(qx[0]);
        win = 16'(qw[0]);
      end else begin
        in_valid_s[sel] = 1'b0;
      end
      ready_now = o_ready[sel];
      @(posedge clk);
      cyc++;
      if (in_valid_s[sel] && ready_now) begin
        void'(qx.pop_front());
        void'(qw.pop_front());
        accepted++;
      end
    end
    in_valid_s[sel] = 1'b0;
    start_s[sel] = 1'b0;
    total++;
    if (done_cyc < 0) begin
      bad++;
      $display("[TB] FAIL run_timeout sel=%0d: done not seen within 400 cycles", sel);
    end
    total++;
    if (overlap !== 1'b0) begin
      bad++;
      $display("[TB] FAIL valid_done_overlap sel=%0d: got %0d want 0", sel, overlap);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      total++;
      if (get_state(s) !== 0 || o_busy[s] !== 1'b0 || o_ready[s] !== 1'b0) begin
        bad++;
        $display("[TB] FAIL reset_ctrl sel=%0d: state=%0d busy=%b ready=%b want 0/0/0",
                 s, get_state(s), o_busy[s], o_ready[s]);
      end
      total++;
      if (o_valid[s] !== 1'b0 || o_done[s] !== 1'b0 || get_data(s) !== 0) begin
        bad++;
        $display("[TB] FAIL reset_out sel=%0d: valid=%b done=%b data=%0d want 0/0/0",
                 s, o_valid[s], o_done[s], get_data(s));
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    qx.delete(); qw.delete();
    push_n(10, 2, 1); push_n(20, 2, 1); push_n(30, 2, 1);
    push_n(1, -5, 3);
    run_layer(0, -1, 0, 1'b0);
    total++;
    if (n_out !== 1 || out_vals[0] !== 120) begin
      bad++;
      $display("[TB] FAIL basic_data: n_out=%0d data=%0d want 1/120", n_out, out_vals[0]);
    end
    total++;
    if (out_cyc[0] !== 9 || done_cyc !== 10) begin
      bad++;
      $display("[TB] FAIL basic_latency: valid@%0d done@%0d want 9/10", out_cyc[0], done_cyc);
    end
    total++;
    if (data0 !== 32'sd120 || o_state0 !== 3'd0) begin
      bad++;
      $display("[TB] FAIL basic_hold: data=%0d state=%0d want 120/0", data0, o_state0);
    end
  endtask

  task automatic test_stall();
    qx.delete(); qw.delete();
    push_n(10, 2, 1); push_n(20, 2, 1); push_n(30, 2, 1);
    push_n(1, -5, 3);
    run_layer(0, 1, 3, 1'b0);
    total++;
    if (n_out !== 1 || out_vals[0] !== 120 || out_cyc[0] !== 12) begin
      bad++;
      $display("[TB] FAIL stall: n_out=%0d data=%0d valid@%0d want 1/120/12",
               n_out, out_vals[0], out_cyc[0]);
    end
  endtask

  task automatic test_negative();
    qx.delete(); qw.delete();
    push_n(-4, 3, 6);
    run_layer(0, -1, 0, 1'b0);
    total++;
    if (n_out !== 1 || out_vals[0] !== 0) begin
      bad++;
      $display("[TB] FAIL negative_relu: n_out=%0d data=%0d want 1/0", n_out, out_vals[0]);
    end
  endtask

  task automatic load_three_pools();
    qx.delete(); qw.delete();
    push_n(1, 1, 1); push_n(2, 1, 1); push_n(3, 1, 1);
    push_n(4, 1, 1); push_n(0, 1, 2);
    push_n(-1, 1, 3); push_n(2, -1, 3);
    push_n(5, 2, 3); push_n(7, 2, 3);
  endtask

  task automatic check_three_pools(input string tag);
    total++;
    if (n_out !== 3 || done_cnt !== 1) begin
      bad++;
      $display("[TB] FAIL %s_count: outputs=%0d dones=%0d want 3/1", tag, n_out, done_cnt);
    end
    total++;
    if (out_vals[0] !== 6 || out_vals[1] !== 0 || out_vals[2] !== 42) begin
      bad++;
      $display("[TB] FAIL %s_data: got %0d,%0d,%0d want 6,0,42", tag,
               out_vals[0], out_vals[1], out_vals[2]);
    end
    total++;
    if (out_cyc[1] !== 18 || out_cyc[2] !== 27 || done_cyc !== 28) begin
      bad++;
      $display("[TB] FAIL %s_timing: valid@%0d,%0d done@%0d want 18,27/28", tag,
               out_cyc[1], out_cyc[2], done_cyc);
    end
  endtask

  task automatic test_restart_ignored();
    load_three_pools();
    run_layer(1, -1, 0, 1'b1);
    check_three_pools("restart");
    total++;
    if (o_busy[1] !== 1'b0 || o_state1 !== 3'd0) begin
      bad++;
      $display("[TB] FAIL restart_idle: busy=%b state=%0d want 0/0", o_busy[1], o_state1);
    end
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    start_s[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_s[1] = 1'b0;
    in_valid_s[1] = 1'b1;
    xin = 16'sd5;
    win = 16'sd5;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if (o_state1 !== 3'd0 || o_busy[1] !== 1'b0 || o_ready[1] !== 1'b0) begin
      bad++;
      $display("[TB] FAIL midreset_ctrl: state=%0d busy=%b ready=%b want 0/0/0",
               o_state1, o_busy[1], o_ready[1]);
    end
    total++;
    if (data1 !== 36'sd0 || o_valid[1] !== 1'b0 || o_done[1] !== 1'b0) begin
      bad++;
      $display("[TB] FAIL midreset_out: data=%0d valid=%b done=%b want 0/0/0",
               data1, o_valid[1], o_done[1]);
    end
    in_valid_s[1] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    load_three_pools();
    run_layer(1, -1, 0, 1'b0);
    check_three_pools("after_reset");
  endtask

  task automatic test_saturation();
    longint expv;
`ifdef ECG_CONV_SAT_EN
    expv = 2147483647;
`else
    expv = 0;
`endif
    qx.delete(); qw.delete();
    push_n(32767, 32767, 6);
    run_layer(0, -1, 0, 1'b0);
    total++;
    if (n_out !== 1 || out_vals[0] !== expv) begin
      bad++;
      $display("[TB] FAIL saturation: n_out=%0d data=%0d want 1/%0d", n_out, out_vals[0], expv);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_negative();
    test_restart_ignored();
    test_mid_reset();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
